// File: rtl/rice_core_pkg.sv
// rice_core_pkg
// Shared types for the rice core CSR access path.
//   CSR_ADDR_W                 : width of a CSR address on the CSR bus
//   rice_core_csr_operation    : CSR op encoding, same as funct3[1:0]
//   rice_core_privilege_level  : privilege level encoding (U/S/M)
package rice_core_pkg;

  localparam int CSR_ADDR_W = 12;

  // Encoding mirrors funct3[1:0] so the decoder can pass the bits straight through
  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } rice_core_csr_operation;

  typedef enum logic [1:0] {
    PRIV_USER       = 2'd0,
    PRIV_SUPERVISOR = 2'd1,
    PRIV_RESERVED   = 2'd2,
    PRIV_MACHINE    = 2'd3
  } rice_core_privilege_level;

endpackage

// File: rtl/rice_bus_if.sv
// rice_bus_if
// Non-posted request/response bus used between the core and its environment.
//   request_valid/request_ready   : request handshake
//   address, write, write_data    : request payload
//   response_valid/response_ready : response handshake
//   read_data, error              : response payload
interface rice_bus_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic              request_valid;
  logic              request_ready;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] write_data;
  logic              response_valid;
  logic              response_ready;
  logic [DATA_W-1:0] read_data;
  logic              error;

  modport master (
    output request_valid, address, write, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, write, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );

endinterface

// File: rtl/rice_core_csr_access.sv
// rice_core_csr_access
// Executes one CSRRW/CSRRS/CSRRC (or immediate form) at a time by issuing a
// read and/or write on the CSR bus, returning the old CSR value for rd or an
// illegal-instruction flag.
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_enable                : core enable; low aborts the operation
//   i_privilege_level       : current privilege level
//   i_valid                 : operation request, taken only while o_busy is low
//   i_operation, i_address  : CSR op and address
//   i_source                : rs1 value or zero-extended uimm
//   i_source_is_zero        : rs1 is x0 / uimm is 0 (suppresses set/clear write)
//   i_rd_is_zero            : rd is x0 (suppresses CSRRW read)
//   o_busy, o_done          : operation in flight / one-cycle completion pulse
//   o_read_data, o_illegal  : old CSR value and illegal flag, valid with o_done
//   csr_if                  : CSR bus master port
//
// Optional feature: define RICE_CORE_CSR_ACCESS_CHECK_EN to reject accesses
// above the current privilege level and writes to read-only CSRs before any
// bus traffic. Without it, illegality comes only from bus error responses.
module rice_core_csr_access
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_privilege_level,
  input  logic                  i_valid,
  input  logic [1:0]            i_operation,
  input  logic [CSR_ADDR_W-1:0] i_address,
  input  logic [XLEN-1:0]       i_source,
  input  logic                  i_source_is_zero,
  input  logic                  i_rd_is_zero,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [XLEN-1:0]       o_read_data,
  output logic                  o_illegal,
  rice_bus_if.master            csr_if
);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_RSP,
    WRITE_REQ,
    WRITE_RSP,
    DONE
  } state_t;

  state_t                 state;
  rice_core_csr_operation op_q;
  logic [XLEN-1:0]        source_q;
  logic                   do_write_q;
  logic                   abort_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   illegal_q;
  logic [XLEN-1:0]        read_data_q;
  logic                   req_valid_q;
  logic                   write_q;
  logic [CSR_ADDR_W-1:0]  address_q;
  logic [XLEN-1:0]        write_data_q;
  logic                   rsp_ready_q;

  rice_core_csr_operation op_in;
  logic                   accept_do_read;
  logic                   accept_do_write;
  logic                   precheck_fail;

  // New CSR value: RW replaces, RS sets bits, RC clears bits
  function automatic logic [XLEN-1:0] merge_write_data(
    input rice_core_csr_operation op,
    input logic [XLEN-1:0]        old_value,
    input logic [XLEN-1:0]        source
  );
    case (op)
      CSR_RW:  return source;
      CSR_RS:  return old_value | source;
      CSR_RC:  return old_value & ~source;
      default: return old_value;
    endcase
  endfunction

  assign op_in = rice_core_csr_operation'(i_operation);

  // Decide which bus transactions an incoming operation needs. CSRRW to x0
  // skips the read; set/clear with a zero source skips the write.
  always_comb begin
    accept_do_read  = !((op_in == CSR_RW) && i_rd_is_zero);
    accept_do_write = (op_in == CSR_RW) || !i_source_is_zero;
`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
    // address[9:8] is the lowest privilege allowed; address[11:10]==11 is read-only
    precheck_fail = (i_address[9:8] > i_privilege_level) ||
                    ((i_address[11:10] == 2'b11) && accept_do_write);
`else
    precheck_fail = 1'b0;
`endif
  end

`ifndef RICE_CORE_CSR_ACCESS_CHECK_EN
  logic unused_privilege;
  assign unused_privilege = ^i_privilege_level;
`endif

  // Main sequencer. Every output is a register so the bus sees clean,
  // stable payloads while a request waits for ready. An abort (enable low)
  // never leaves a response outstanding: once a request has been accepted
  // the response handshake is always completed before returning to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      op_q         <= CSR_RW;
      source_q     <= '0;
      do_write_q   <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      read_data_q  <= '0;
      req_valid_q  <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      rsp_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && i_enable) begin
            op_q        <= op_in;
            source_q    <= i_source;
            do_write_q  <= accept_do_write;
            abort_q     <= 1'b0;
            busy_q      <= 1'b1;
            illegal_q   <= 1'b0;
            read_data_q <= '0;
            address_q   <= i_address;
            if (precheck_fail) begin
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= DONE;
            end else if (accept_do_read) begin
              req_valid_q <= 1'b1;
              write_q     <= 1'b0;
              state       <= READ_REQ;
            end else begin
              req_valid_q  <= 1'b1;
              write_q      <= 1'b1;
              write_data_q <= i_source;
              state        <= WRITE_REQ;
            end
          end
        end

        // A request that is accepted in the same cycle enable drops still
        // owes a response, so it goes to the response state marked aborted.
        READ_REQ, WRITE_REQ: begin
          if (csr_if.request_ready) begin
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            abort_q     <= !i_enable;
            state       <= (state == READ_REQ) ? READ_RSP : WRITE_RSP;
          end else if (!i_enable) begin
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        READ_RSP, WRITE_RSP: begin
          if (csr_if.response_valid) begin
            rsp_ready_q <= 1'b0;
            if (abort_q || !i_enable) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else if (csr_if.error) begin
              illegal_q   <= 1'b1;
              read_data_q <= '0;
              done_q      <= 1'b1;
              state       <= DONE;
            end else if ((state == READ_RSP) && do_write_q) begin
              read_data_q  <= csr_if.read_data;
              req_valid_q  <= 1'b1;
              write_q      <= 1'b1;
              write_data_q <= merge_write_data(op_q, csr_if.read_data, source_q);
              state        <= WRITE_REQ;
            end else begin
              if (state == READ_RSP) begin
                read_data_q <= csr_if.read_data;
              end
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else if (!i_enable) begin
            abort_q <= 1'b1;
          end
        end

        DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          illegal_q <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The completion pulse is withheld if enable drops during the DONE cycle
  assign o_done      = done_q & i_enable;
  assign o_busy      = busy_q;
  assign o_illegal   = illegal_q;
  assign o_read_data = read_data_q;

  assign csr_if.request_valid  = req_valid_q;
  assign csr_if.address        = address_q;
  assign csr_if.write          = write_q;
  assign csr_if.write_data     = write_data_q;
  assign csr_if.response_ready = rsp_ready_q;

endmodule

// File: tb/tb_rice_core_csr_access.sv
// tb_rice_core_csr_access
// Self-checking bench for rice_core_csr_access: a behavioural CSR slave with
// configurable request/response delays, a table of directed vectors, hand
// sequences for enable abort and mid-request reset, and randomized operations
// checked against a reference model. Follows RICE_CORE_CSR_ACCESS_CHECK_EN.
module tb_rice_core_csr_access;
  import rice_core_pkg::*;

  localparam int XLEN = 32;

  logic            i_clk;
  logic            i_rst;
  logic            i_enable;
  logic [1:0]      i_privilege_level;
  logic            i_valid;
  logic [1:0]      i_operation;
  logic [11:0]     i_address;
  logic [XLEN-1:0] i_source;
  logic            i_source_is_zero;
  logic            i_rd_is_zero;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_read_data;
  logic            o_illegal;

  rice_bus_if #(.ADDR_W(12), .DATA_W(XLEN)) bus ();

  rice_core_csr_access #(.XLEN(XLEN)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_enable          (i_enable),
    .i_privilege_level (i_privilege_level),
    .i_valid           (i_valid),
    .i_operation       (i_operation),
    .i_address         (i_address),
    .i_source          (i_source),
    .i_source_is_zero  (i_source_is_zero),
    .i_rd_is_zero      (i_rd_is_zero),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_read_data       (o_read_data),
    .o_illegal         (o_illegal),
    .csr_if            (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        srcz;
    logic        rdz;
    logic [1:0]  priv;
    logic [31:0] exp_data;
    logic        exp_ill;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      avail;
  } rsp_t;

  int checks = 0;
  int passed = 0;

  // Slave-side state
  int          req_delay = 0;
  int          rsp_delay = 0;
  bit          stall_req = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  logic [31:0] last_wdata = '0;
  longint      cyc = 0;
  rsp_t        pending[$];
  logic [31:0] slave_mem [logic [11:0]];
  bit          slave_err [logic [11:0]];

  // Reference model state
  logic [31:0] model_mem [logic [11:0]];
  bit          model_err [logic [11:0]];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic vec_t mkVec(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                                 input logic srcz, input logic rdz, input logic [1:0] priv,
                                 input logic [31:0] d, input logic ill, input int lat,
                                 input int rds, input int wrs, input logic [31:0] wd);
    vec_t v;
    v.op = op; v.addr = addr; v.src = src; v.srcz = srcz; v.rdz = rdz; v.priv = priv;
    v.exp_data = d; v.exp_ill = ill; v.exp_lat = lat;
    v.exp_reads = rds; v.exp_writes = wrs; v.exp_wdata = wd;
    return v;
  endfunction

  task automatic initMemories();
    slave_mem.delete(); model_mem.delete(); slave_err.delete(); model_err.delete();
    slave_mem[12'h340] = 32'h0000_1234; model_mem[12'h340] = 32'h0000_1234;
    slave_mem[12'h300] = 32'h0000_1800; model_mem[12'h300] = 32'h0000_1800;
    slave_mem[12'hF14] = 32'h0000_0005; model_mem[12'hF14] = 32'h0000_0005;
    slave_mem[12'h341] = 32'h8000_0000; model_mem[12'h341] = 32'h8000_0000;
    slave_mem[12'h100] = 32'h0000_0022; model_mem[12'h100] = 32'h0000_0022;
    slave_mem[12'hC00] = 32'h0000_1000; model_mem[12'hC00] = 32'h0000_1000;
    slave_mem[12'h345] = 32'hCAFE_0001; model_mem[12'h345] = 32'hCAFE_0001;
    slave_err[12'h7C0] = 1'b1;          model_err[12'h7C0] = 1'b1;
  endtask

  // Reference model: what a CSR instruction must do, from the ISA-level rules
  task automatic predict(input vec_t vin, output vec_t v);
    bit rd, wr, pre, err;
    logic [31:0] old, newv;
    v = vin;
    rd  = !(vin.op == CSR_RW && vin.rdz);
    wr  = (vin.op == CSR_RW) || !vin.srcz;
    pre = 1'b0;
`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
    pre = (vin.addr[9:8] > vin.priv) || ((vin.addr[11:10] == 2'b11) && wr);
`endif
    old = model_mem.exists(vin.addr) ? model_mem[vin.addr] : 32'h0;
    err = model_err.exists(vin.addr);
    v.exp_data = '0; v.exp_ill = 1'b0; v.exp_reads = 0; v.exp_writes = 0;
    v.exp_wdata = '0; v.exp_lat = 1;
    if (pre) begin
      v.exp_ill = 1'b1;
    end else if (rd && err) begin
      v.exp_ill = 1'b1; v.exp_reads = 1; v.exp_lat = 3;
    end else begin
      v.exp_reads  = int'(rd);
      v.exp_writes = int'(wr);
      v.exp_lat    = 1 + 2 * int'(rd) + 2 * int'(wr);
      case (vin.op)
        CSR_RW:  newv = vin.src;
        CSR_RS:  newv = old | vin.src;
        CSR_RC:  newv = old & ~vin.src;
        default: newv = old;
      endcase
      if (wr) v.exp_wdata = newv;
      if (wr && err) v.exp_ill = 1'b1;
      else begin
        v.exp_data = rd ? old : 32'h0;
        if (wr) model_mem[vin.addr] = newv;
      end
    end
  endtask

  // Behavioural CSR slave: decides ready/response for each cycle at the
  // falling edge so the DUT samples settled values at the rising edge.
  initial begin
    int wait_cnt;
    rsp_t r;
    logic [11:0] a;
    bus.request_ready = 1'b0; bus.response_valid = 1'b0;
    bus.read_data = '0; bus.error = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        bus.request_ready = 1'b0; bus.response_valid = 1'b0;
        bus.read_data = '0; bus.error = 1'b0;
        wait_cnt = 0;
        pending.delete();
      end else begin
        bus.request_ready = 1'b0;
        if (bus.request_valid && !stall_req) begin
          if (wait_cnt >= req_delay) begin
            bus.request_ready = 1'b1;
            wait_cnt = 0;
            a = bus.address;
            r.err = slave_err.exists(a);
            if (bus.write) begin
              n_writes++;
              last_wdata = bus.write_data;
              r.data = '0;
              if (!r.err) slave_mem[a] = bus.write_data;
            end else begin
              n_reads++;
              r.data = (r.err || !slave_mem.exists(a)) ? 32'h0 : slave_mem[a];
            end
            r.avail = cyc + 1 + longint'(rsp_delay);
            pending.push_back(r);
          end else begin
            wait_cnt++;
          end
        end
        if (pending.size() > 0 && cyc >= pending[0].avail) begin
          bus.response_valid = 1'b1;
          bus.read_data = pending[0].data;
          bus.error = pending[0].err;
          if (bus.response_ready) void'(pending.pop_front());
        end else begin
          bus.response_valid = 1'b0; bus.read_data = '0; bus.error = 1'b0;
        end
      end
    end
  end

  // Issue one operation and wait (bounded) for o_done. With junk set, i_valid
  // and i_address are wiggled while busy; the DUT must ignore them.
  task automatic applyStimulus(input vec_t v, input bit junk, output logic [31:0] got_data,
                               output logic got_ill, output int lat, output bit got_done);
    @(negedge i_clk);
    i_valid = 1'b1; i_operation = v.op; i_address = v.addr; i_source = v.src;
    i_source_is_zero = v.srcz; i_rd_is_zero = v.rdz; i_privilege_level = v.priv;
    lat = 0; got_done = 1'b0; got_data = '0; got_ill = 1'b0;
    while (lat < 80) begin
      @(negedge i_clk);
      lat++;
      if (o_done) begin
        got_done = 1'b1; got_data = o_read_data; got_ill = o_illegal;
        i_valid = 1'b0;
        break;
      end
      i_valid = junk && o_busy && ($urandom_range(0, 3) == 0);
      if (i_valid) i_address = 12'($urandom);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v, e;
    logic [11:0] addr_pool[7];
    logic [1:0]  priv_pool[3];
    logic [31:0] got_data;
    logic        got_ill;
    int          lat, rd0, wr0, done_cnt;
    bit          got_done;

    i_rst = 1'b1; i_enable = 1'b1; i_privilege_level = PRIV_MACHINE; i_valid = 1'b0;
    i_operation = CSR_RW; i_address = '0; i_source = '0;
    i_source_is_zero = 1'b0; i_rd_is_zero = 1'b0;
    initMemories();

    vecs[0] = mkVec(CSR_RW, 12'h340, 32'hDEAD_BEEF, 0, 0, PRIV_MACHINE, 32'h1234, 0, 5, 1, 1, 32'hDEAD_BEEF);
    vecs[1] = mkVec(CSR_RS, 12'h300, 32'h8, 0, 0, PRIV_MACHINE, 32'h1800, 0, 5, 1, 1, 32'h1808);
    vecs[2] = mkVec(CSR_RC, 12'h300, 32'h8, 0, 0, PRIV_MACHINE, 32'h1808, 0, 5, 1, 1, 32'h1800);
    vecs[3] = mkVec(CSR_RS, 12'h300, 32'h0, 1, 0, PRIV_MACHINE, 32'h1800, 0, 3, 1, 0, 32'h0);
    vecs[4] = mkVec(CSR_RW, 12'h340, 32'h55, 0, 1, PRIV_MACHINE, 32'h0, 0, 3, 0, 1, 32'h55);
    vecs[5] = mkVec(CSR_RS, 12'h7C0, 32'h1, 0, 0, PRIV_MACHINE, 32'h0, 1, 3, 1, 0, 32'h0);
`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
    vecs[6] = mkVec(CSR_RW, 12'hF14, 32'h1, 0, 0, PRIV_MACHINE, 32'h0, 1, 1, 0, 0, 32'h0);
    vecs[7] = mkVec(CSR_RS, 12'h300, 32'h0, 1, 0, PRIV_USER, 32'h0, 1, 1, 0, 0, 32'h0);
`else
    vecs[6] = mkVec(CSR_RW, 12'hF14, 32'h1, 0, 0, PRIV_MACHINE, 32'h5, 0, 5, 1, 1, 32'h1);
    vecs[7] = mkVec(CSR_RS, 12'h300, 32'h0, 1, 0, PRIV_USER, 32'h1800, 0, 3, 1, 0, 32'h0);
`endif
    vecs[8] = mkVec(CSR_RC, 12'h300, 32'h800, 0, 1, PRIV_MACHINE, 32'h1800, 0, 5, 1, 1, 32'h1000);
    vecs[9] = mkVec(CSR_RW, 12'h7C0, 32'hABCD, 0, 1, PRIV_MACHINE, 32'h0, 1, 3, 0, 1, 32'hABCD);

    // Reset state
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("reset o_busy", 32'(o_busy), 32'h0);
    checkOutput("reset o_done", 32'(o_done), 32'h0);
    checkOutput("reset o_illegal", 32'(o_illegal), 32'h0);
    checkOutput("reset o_read_data", o_read_data, 32'h0);
    checkOutput("reset request_valid", 32'(bus.request_valid), 32'h0);
    checkOutput("reset response_ready", 32'(bus.response_ready), 32'h0);

    // Directed table on a zero-wait slave
    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      rd0 = n_reads; wr0 = n_writes; last_wdata = '0;
      applyStimulus(vecs[i], 1'b1, got_data, got_ill, lat, got_done);
      checkOutput($sformatf("vec%0d done", i), 32'(got_done), 32'h1);
      checkOutput($sformatf("vec%0d read_data", i), got_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d illegal", i), 32'(got_ill), 32'(vecs[i].exp_ill));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d reads", i), 32'(n_reads - rd0), 32'(vecs[i].exp_reads));
      checkOutput($sformatf("vec%0d writes", i), 32'(n_writes - wr0), 32'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0)
        checkOutput($sformatf("vec%0d write_data", i), last_wdata, vecs[i].exp_wdata);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d done pulse", i), 32'(o_done), 32'h0);
      checkOutput($sformatf("vec%0d idle busy", i), 32'(o_busy), 32'h0);
    end

    // Enable drop in READ_RSP while the response is held off three cycles
    $display("[TB] enable drop during read response");
    initMemories();
    rsp_delay = 3; rd0 = n_reads; wr0 = n_writes; done_cnt = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_operation = CSR_RS; i_address = 12'h300; i_source = '0;
    i_source_is_zero = 1'b1; i_rd_is_zero = 1'b0; i_privilege_level = PRIV_MACHINE;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("abort rsp_ready c2", 32'(bus.response_ready), 32'h1);
    i_enable = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge i_clk);
      if (o_done) done_cnt++;
      if (k == 3 || k == 4) begin
        checkOutput($sformatf("abort rsp_ready c%0d", k), 32'(bus.response_ready), 32'h1);
        checkOutput($sformatf("abort busy c%0d", k), 32'(o_busy), 32'h1);
      end
    end
    checkOutput("abort no done", 32'(done_cnt), 32'h0);
    checkOutput("abort response consumed", 32'(pending.size()), 32'h0);
    checkOutput("abort idle busy", 32'(o_busy), 32'h0);
    checkOutput("abort rsp_ready low", 32'(bus.response_ready), 32'h0);
    checkOutput("abort reads", 32'(n_reads - rd0), 32'h1);
    checkOutput("abort writes", 32'(n_writes - wr0), 32'h0);
    i_enable = 1'b1; rsp_delay = 0;

    // Randomized operations against the reference model
    $display("[TB] randomized operations");
    addr_pool = '{12'h340, 12'h300, 12'h7C0, 12'hF14, 12'h341, 12'h100, 12'hC00};
    priv_pool = '{PRIV_USER, PRIV_SUPERVISOR, PRIV_MACHINE};
    for (int n = 0; n < 40; n++) begin
      v.op   = 2'($urandom_range(1, 3));
      v.addr = addr_pool[$urandom_range(0, 6)];
      v.srcz = ($urandom_range(0, 2) == 0);
      v.src  = v.srcz ? 32'h0 : $urandom;
      v.rdz  = ($urandom_range(0, 1) == 1);
      v.priv = priv_pool[$urandom_range(0, 2)];
      req_delay = $urandom_range(0, 2);
      rsp_delay = $urandom_range(0, 2);
      predict(v, e);
      rd0 = n_reads; wr0 = n_writes; last_wdata = '0;
      applyStimulus(v, 1'b1, got_data, got_ill, lat, got_done);
      checkOutput($sformatf("rnd%0d done", n), 32'(got_done), 32'h1);
      checkOutput($sformatf("rnd%0d read_data", n), got_data, e.exp_data);
      checkOutput($sformatf("rnd%0d illegal", n), 32'(got_ill), 32'(e.exp_ill));
      checkOutput($sformatf("rnd%0d reads", n), 32'(n_reads - rd0), 32'(e.exp_reads));
      checkOutput($sformatf("rnd%0d writes", n), 32'(n_writes - wr0), 32'(e.exp_writes));
      if (e.exp_writes > 0)
        checkOutput($sformatf("rnd%0d write_data", n), last_wdata, e.exp_wdata);
    end
    req_delay = 0; rsp_delay = 0;

    // Reset while a write request is waiting for ready
    $display("[TB] reset during write request");
    v = mkVec(CSR_RS, 12'h345, 32'h0, 1, 0, PRIV_MACHINE, 32'h0, 0, 0, 0, 0, 32'h0);
    applyStimulus(v, 1'b0, got_data, got_ill, lat, got_done);
    checkOutput("prereset read_data", got_data, 32'hCAFE_0001);
    stall_req = 1'b1; wr0 = n_writes;
    @(negedge i_clk);
    i_valid = 1'b1; i_operation = CSR_RW; i_address = 12'h340; i_source = 32'h77;
    i_source_is_zero = 1'b0; i_rd_is_zero = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    checkOutput("stall request_valid", 32'(bus.request_valid), 32'h1);
    checkOutput("stall write", 32'(bus.write), 32'h1);
    @(negedge i_clk);
    checkOutput("stall write_data held", bus.write_data, 32'h77);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("midrst o_busy", 32'(o_busy), 32'h0);
    checkOutput("midrst o_done", 32'(o_done), 32'h0);
    checkOutput("midrst o_illegal", 32'(o_illegal), 32'h0);
    checkOutput("midrst o_read_data", o_read_data, 32'h0);
    checkOutput("midrst request_valid", 32'(bus.request_valid), 32'h0);
    checkOutput("midrst response_ready", 32'(bus.response_ready), 32'h0);
    checkOutput("midrst address", 32'(bus.address), 32'h0);
    checkOutput("midrst write_data", bus.write_data, 32'h0);
    i_rst = 1'b0; stall_req = 1'b0;
    @(negedge i_clk);
    checkOutput("midrst no write", 32'(n_writes - wr0), 32'h0);
    applyStimulus(v, 1'b0, got_data, got_ill, lat, got_done);
    checkOutput("postreset read_data", got_data, 32'hCAFE_0001);
    checkOutput("postreset latency", 32'(lat), 32'h3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
